// File: rtl/pixel_fb_writer.sv
// pixel_fb_writer: buffers rasterizer pixels, clips them to the screen and writes framebuffer words;
// also performs a full-screen clear sweep on request.
module pixel_fb_writer #(
  parameter int          FB_W        = 640,
  parameter int          FB_H        = 480,
  parameter int          ADDR_W      = 19,
  parameter int          DEPTH       = 16,
  parameter logic [31:0] CLEAR_COLOR = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [95:0]       wr_data,
  input  logic              wr_en,
  output logic              full,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  input  logic              mem_ack,
  output logic [15:0]       drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_W*FB_H-1);
  typedef enum logic [1:0] {IDLE, DRAW, CLEAR} state_t;
  state_t state_q, state_d;
  logic [95:0] fifo_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic st_vld_q;
  logic signed [31:0] st_x_q, st_y_q, lin;
  logic [31:0] st_c_q, data_q, data_d;
  logic req_q, req_d, pend_q, pend_d, done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0] drop_q, drop_d;
  logic push, pop, empty, clip, st_go, pipe_idle;
  assign empty = cnt_q == '0;
  assign full = cnt_q == FULL_CNT || pend_q || state_q == CLEAR;
  assign busy = pend_q || state_q == CLEAR;
  assign push = wr_en && !full;
  assign clip = st_x_q < 0 || st_x_q >= FB_W || st_y_q < 0 || st_y_q >= FB_H;
  // Clipped pixels leave the stage without needing the memory port.
  assign st_go = st_vld_q && (clip || !req_q || mem_ack);
  assign pop = !empty && (!st_vld_q || st_go);
  assign pipe_idle = empty && !st_vld_q && !req_q;
  assign lin = st_y_q * FB_W + st_x_q;
  assign mem_req = req_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign clear_done = done_q;
  assign drop_cnt = drop_q;
  always_comb begin
    state_d = state_q;
    pend_d = pend_q || (clear_start && state_q != CLEAR);
    done_d = 1'b0;
    req_d = req_q && !mem_ack;
    addr_d = addr_q;
    data_d = data_q;
    drop_d = (st_go && clip && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    if (st_go && !clip) begin
      req_d = 1'b1;
      addr_d = lin[ADDR_W-1:0];
      data_d = st_c_q;
    end
    if (state_q != CLEAR) begin
      state_d = (pend_q && pipe_idle) ? CLEAR : pipe_idle ? IDLE : DRAW;
      if (pend_q && pipe_idle) begin
        req_d = 1'b1;
        addr_d = '0;
        data_d = CLEAR_COLOR;
      end
    end else if (req_q && mem_ack) begin
      state_d = addr_q == LAST ? IDLE : CLEAR;
      pend_d = addr_q != LAST;
      done_d = addr_q == LAST;
      req_d = addr_q != LAST;
      addr_d = addr_q + ADDR_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= wr_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      st_vld_q <= 1'b0;
      st_x_q <= '0;
      st_y_q <= '0;
      st_c_q <= '0;
      req_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_q + AW'(push);
      rp_q <= rp_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      st_vld_q <= pop || (st_vld_q && !st_go);
      if (pop) begin
        st_x_q <= fifo_q[rp_q][95:64];
        st_y_q <= fifo_q[rp_q][63:32];
        st_c_q <= fifo_q[rp_q][31:0];
      end
      req_q <= req_d;
      addr_q <= addr_d;
      data_q <= data_d;
      pend_q <= pend_d;
      done_q <= done_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_pixel_fb_writer.sv
// tb_pixel_fb_writer: random and directed stimulus checked against a queue-based write-log model.
module tb_pixel_fb_writer;
  localparam int FB_W = 4, FB_H = 3, ADDR_W = 4, DEPTH = 4;
  localparam logic [31:0] CC = 32'h5A5A00FF;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [95:0] wr_data = '0;
  logic wr_en = 1'b0, clear_start = 1'b0, mem_ack = 1'b0;
  logic full, busy, clear_done, mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_data;
  logic [15:0] drop_cnt;
  int checks = 0, errors = 0;
  int ack_mode = 0, model_drop = 0, wr_cnt = 0, done_cnt = 0, w0, d0;
  bit model_busy = 0, prev_hold = 0;
  logic [ADDR_W-1:0] prev_addr;
  logic [31:0] prev_data;
  logic [35:0] exp_q[$];
  pixel_fb_writer #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_COLOR(CC)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .full(full),
    .clear_start(clear_start), .busy(busy), .clear_done(clear_done), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack), .drop_cnt(drop_cnt));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1 mem_ack = ack_mode == 1 ? 1'b1 : ack_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model_pixel(input logic [95:0] p);
    int x = p[95:64];
    int y = p[63:32];
    if (x < 0 || x >= FB_W || y < 0 || y >= FB_H) model_drop++;
    else exp_q.push_back({ADDR_W'(y * FB_W + x), p[31:0]});
  endfunction
  always @(negedge clk) begin
    if (!rst_n) prev_hold = 0;
    else begin
      if (prev_hold) chk("req_hold", {mem_req, mem_addr, mem_data}, {1'b1, prev_addr, prev_data});
      prev_hold = mem_req && !mem_ack;
      prev_addr = mem_addr;
      prev_data = mem_data;
      if (mem_req && mem_ack) begin
        wr_cnt++;
        chk("wr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("wr_log", {mem_addr, mem_data}, exp_q.pop_front());
      end
      if (wr_en && !full) model_pixel(wr_data);
      if (clear_done) begin
        done_cnt++;
        model_busy = 0;
      end
      chk("busy", busy, model_busy);
      if (clear_start && !model_busy) begin
        model_busy = 1;
        for (int a = 0; a < FB_W * FB_H; a++) exp_q.push_back({ADDR_W'(a), CC});
      end
    end
  end
  task automatic push(input int x, input int y, input logic [31:0] c);
    bit acc = 0;
    wr_data = {x, y, c};
    wr_en = 1'b1;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = !full;
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    chk("push_accept", acc, 1);
  endtask
  task automatic set_ack(input int m);
    @(negedge clk);
    ack_mode = m;
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
  endtask
  task automatic pulse_clear();
    clear_start = 1'b1;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 300 && !clear_done; i++) begin
      @(posedge clk);
      #1;
    end
    chk("clear_done_seen", clear_done, 1);
    chk("busy_at_done", busy, 0);
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, {full, busy, clear_done, mem_req, mem_addr, mem_data, drop_cnt}, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    set_ack(1);
    push(2, 1, 32'hAABBCCDD);
    chk("t1_req_e0", mem_req, 0);
    @(posedge clk);
    #1;
    chk("t1_req_e1", mem_req, 0);
    @(posedge clk);
    #1;
    chk("t1_write", {mem_req, mem_addr, mem_data}, {1'b1, 4'd6, 32'hAABBCCDD});
    @(posedge clk);
    #1;
    chk("t1_one_cycle", mem_req, 0);
    drain();
    w0 = wr_cnt;
    push(-1, 0, 32'h1);
    push(4, 0, 32'h2);
    push(0, 3, 32'h3);
    push(3, 2, 32'h4);
    drain();
    chk("t2_drop", drop_cnt, 3);
    chk("t2_writes", wr_cnt - w0, 1);
    set_ack(0);
    for (int i = 0; i < 6; i++) push(i % FB_W, i / FB_W, 32'hC0DE0000 + i);
    chk("t3_full", full, 1);
    chk("t3_held", {mem_req, mem_addr, mem_data}, {1'b1, 4'd0, 32'hC0DE0000});
    fork
      push(3, 2, 32'hC0DE0006);
      begin
        @(negedge clk);
        ack_mode = 1;
        @(posedge clk);
        #1;
        w0 = wr_cnt;
        repeat (7) @(posedge clk);
        #1;
        chk("t3_rate", wr_cnt - w0, 7);
      end
    join
    drain();
    push(1, 1, 32'h11111111);
    push(2, 2, 32'h22222222);
    d0 = done_cnt;
    pulse_clear();
    chk("t4_full", {full, busy}, 2'b11);
    wait_done();
    chk("t4_all_written", exp_q.size(), 0);
    @(posedge clk);
    #1;
    chk("t4_done_pulse", clear_done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_done_once", done_cnt - d0, 1);
    set_ack(2);
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      push(int'($urandom_range(0, 7)) - 2, int'($urandom_range(0, 6)) - 2, $urandom);
    end
    drain();
    chk("t5_drop", drop_cnt, model_drop);
    set_ack(1);
    pulse_clear();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 4'd5) break;
    end
    chk("t6_at_addr5", {mem_req, mem_addr}, {1'b1, 4'd5});
    #2 rst_n = 1'b0;
    #1 chk_zero("t6_async_reset");
    exp_q.delete();
    model_busy = 0;
    model_drop = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_after_reset", {full, busy, mem_req}, 0);
    pulse_clear();
    @(posedge clk);
    #1;
    chk("t6_restart_addr", {mem_req, mem_addr, mem_data}, {1'b1, 4'd0, CC});
    wait_done();
    drain();
    chk("t6_drop", drop_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
